// File: rtl/fta_resp_merge.sv
// fta_resp_merge: merges the FTA response streams of CHANNELS independent
// channels into one registered response stream. Each channel has its own
// FIFO, and a round-robin arbiter drains one entry per cycle in total.
//
// Response word layout (fta_cmd_response128_t, flattened, RESP_W = 171 bits):
//   [170:163] tid   [162:131] adr   [130:3] dat   [2] err   [1] rty   [0] ack
//
// Ports:
//   clk     in   clock, all state changes on the rising edge
//   rst     in   asynchronous active-low reset
//   resp    in   CHANNELS response words, channel i at [i*RESP_W +: RESP_W]
//   resp_o  out  merged response, registered; all zeros when nothing is granted
//   full_o  out  per-channel FIFO full, registered
//   ovf_o   out  per-channel sticky overflow, cleared only by reset
module fta_resp_merge #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned DEPTH    = 16,
    localparam int unsigned RESP_W  = 171
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS*RESP_W-1:0]   resp,
    output logic [RESP_W-1:0]            resp_o,
    output logic [CHANNELS-1:0]          full_o,
    output logic [CHANNELS-1:0]          ovf_o
);

    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW      = AW + 1;
    localparam int unsigned LW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned ACK_BIT = 0;
    localparam int unsigned RTY_BIT = 1;

    logic [RESP_W-1:0]   mem_q    [CHANNELS][DEPTH];
    logic [AW-1:0]       wr_ptr_q [CHANNELS];
    logic [AW-1:0]       rd_ptr_q [CHANNELS];
    logic [CW-1:0]       cnt_q    [CHANNELS];
    logic [CW-1:0]       cnt_d    [CHANNELS];
    logic [RESP_W-1:0]   wdata    [CHANNELS];
    logic [CHANNELS-1:0] push;
    logic [CHANNELS-1:0] pop;
    logic [CHANNELS-1:0] full_q;
    logic [CHANNELS-1:0] ovf_q;
    logic [LW-1:0]       last_q;
    logic [LW-1:0]       gnt_idx;
    logic [LW-1:0]       cand;
    logic                gnt_vld;
    logic [RESP_W-1:0]   resp_q;
    logic [RESP_W-1:0]   resp_d;

    // Capture: only ack qualifies an entry; the stored copy never carries rty.
    // Full is the registered flag, so a pop in the same cycle does not make
    // room for a write.
    always_comb begin
        push = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            wdata[i]          = resp[i*RESP_W +: RESP_W];
            wdata[i][RTY_BIT] = 1'b0;
            push[i]           = wdata[i][ACK_BIT] && !full_q[i];
        end
    end

    // Round-robin: first non-empty channel scanning last+1, last+2, ... with wrap.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 1; k <= int'(CHANNELS); k++) begin
            cand = LW'((int'(last_q) + k) % int'(CHANNELS));
            if (!gnt_vld && (cnt_q[cand] != '0)) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        pop = '0;
        if (gnt_vld) begin
            pop[gnt_idx] = 1'b1;
        end
        resp_d = gnt_vld ? mem_q[gnt_idx][rd_ptr_q[gnt_idx]] : '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            cnt_d[i] = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            full_q <= '0;
            ovf_q  <= '0;
            last_q <= LW'(CHANNELS - 1);
            resp_q <= '0;
        end else begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                if (push[i]) begin
                    wr_ptr_q[i] <= wr_ptr_q[i] + AW'(1);
                end
                if (pop[i]) begin
                    rd_ptr_q[i] <= rd_ptr_q[i] + AW'(1);
                end
                cnt_q[i]  <= cnt_d[i];
                full_q[i] <= (cnt_d[i] == CW'(DEPTH));
                if (wdata[i][ACK_BIT] && full_q[i]) begin
                    ovf_q[i] <= 1'b1;
                end
            end
            if (gnt_vld) begin
                last_q <= gnt_idx;
            end
            resp_q <= resp_d;
        end
    end

    // Storage needs no reset: an entry is only read once its count says it is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= wdata[i];
            end
        end
    end

    assign resp_o = resp_q;
    assign full_o = full_q;
    assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_fta_resp_merge.sv
module tb_fta_resp_merge;

    localparam int RW = 171;

    logic            clk = 1'b0;
    logic            rst;
    logic [2*RW-1:0] resp;
    logic [RW-1:0]   resp_o;
    logic [1:0]      full_o;
    logic [1:0]      ovf_o;

    int n_vec = 0;
    int n_err = 0;

    // Reference model for the overflow scenario.
    logic [RW-1:0] mq0[$];
    logic [RW-1:0] mq1[$];
    int            m_last;
    logic [1:0]    m_ovf;
    logic          saw_full0;

    logic [RW-1:0] e_in;
    logic [RW-1:0] e_a;
    logic [RW-1:0] e_b;

    fta_resp_merge #(
        .CHANNELS(2),
        .DEPTH   (16)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .resp  (resp),
        .resp_o(resp_o),
        .full_o(full_o),
        .ovf_o (ovf_o)
    );

    always #5 clk = ~clk;

    function automatic logic [RW-1:0] mk(input logic ack, input logic rty, input logic err,
                                         input logic [7:0] tid, input logic [31:0] adr,
                                         input logic [127:0] dat);
        return {tid, adr, dat, err, rty, ack};
    endfunction

    task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic model_cycle(input logic [1:0] ack, input logic [RW-1:0] d0,
                               input logic [RW-1:0] d1);
        logic [RW-1:0] exp_o;
        int            g;
        int            c;
        logic          acc0;
        logic          acc1;
        g = -1;
        for (int k = 1; k <= 2; k++) begin
            c = (m_last + k) % 2;
            if (g < 0 && ((c == 0 && mq0.size() > 0) || (c == 1 && mq1.size() > 0))) g = c;
        end
        // Full is judged on the count before this edge, pop or not.
        acc0 = ack[0] && (mq0.size() < 16);
        acc1 = ack[1] && (mq1.size() < 16);
        if (ack[0] && !acc0) m_ovf[0] = 1'b1;
        if (ack[1] && !acc1) m_ovf[1] = 1'b1;
        exp_o = '0;
        if (g == 0) exp_o = mq0.pop_front();
        else if (g == 1) exp_o = mq1.pop_front();
        if (g >= 0) m_last = g;
        if (acc0) mq0.push_back(d0);
        if (acc1) mq1.push_back(d1);
        resp = '0;
        if (ack[0]) resp[0 +: RW] = d0;
        if (ack[1]) resp[RW +: RW] = d1;
        step();
        check("ovf_resp", resp_o, exp_o);
        check("ovf_full", RW'(full_o), RW'({mq1.size() == 16, mq0.size() == 16}));
        check("ovf_flag", RW'(ovf_o), RW'(m_ovf));
        if (full_o[0]) saw_full0 = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst  = 1'b0;
        resp = '0;
        step();
        step();
        check("rst_resp", resp_o, '0);
        check("rst_full", RW'(full_o), RW'(2'b00));
        check("rst_ovf", RW'(ovf_o), RW'(2'b00));
        rst = 1'b1;

        // Single response: rty is stripped, err kept, 2-cycle latency.
        e_in = mk(1'b1, 1'b1, 1'b1, 8'h10, 32'h1000, {4{32'hA5A5_A5A5}});
        e_a  = mk(1'b1, 1'b0, 1'b1, 8'h10, 32'h1000, {4{32'hA5A5_A5A5}});
        resp[0 +: RW] = e_in;
        step();
        resp = '0;
        check("single_t1", resp_o, '0);
        step();
        check("single_t2", resp_o, e_a);
        step();
        check("single_t3", resp_o, '0);

        // Simultaneous arrival from reset: channel 0 first.
        do_reset();
        e_a = mk(1'b1, 1'b0, 1'b0, 8'h01, 32'h0, 128'h11);
        e_b = mk(1'b1, 1'b0, 1'b0, 8'h02, 32'h0, 128'h22);
        resp[0 +: RW]  = e_a;
        resp[RW +: RW] = e_b;
        step();
        resp = '0;
        step();
        check("simul_first", resp_o, e_a);
        step();
        check("simul_second", resp_o, e_b);
        step();
        check("simul_idle", resp_o, '0);

        // After a lone channel-0 grant, channel 1 wins the next tie.
        e_a = mk(1'b1, 1'b0, 1'b0, 8'h01, 32'h0, 128'h33);
        resp[0 +: RW] = e_a;
        step();
        resp = '0;
        step();
        check("rr_lone", resp_o, e_a);
        e_a = mk(1'b1, 1'b0, 1'b0, 8'h01, 32'h0, 128'h44);
        e_b = mk(1'b1, 1'b0, 1'b0, 8'h02, 32'h0, 128'h55);
        resp[0 +: RW]  = e_a;
        resp[RW +: RW] = e_b;
        step();
        resp = '0;
        step();
        check("rr_first", resp_o, e_b);
        step();
        check("rr_second", resp_o, e_a);
        step();
        check("rr_idle", resp_o, '0);

        // Streaming on channel 1, back-to-back.
        for (int k = 1; k <= 5; k++) begin
            resp[RW +: RW] = mk(1'b1, 1'b0, 1'b0, 8'h21, 32'h2000, 128'(k));
            step();
            if (k >= 2) check("stream", resp_o, mk(1'b1, 1'b0, 1'b0, 8'h21, 32'h2000, 128'(k - 1)));
        end
        resp = '0;
        step();
        check("stream_last", resp_o, mk(1'b1, 1'b0, 1'b0, 8'h21, 32'h2000, 128'(5)));
        step();
        check("stream_idle", resp_o, '0);

        // Overflow: both channels flood, each is drained on alternate cycles.
        do_reset();
        m_last    = 1;
        m_ovf     = 2'b00;
        saw_full0 = 1'b0;
        for (int k = 1; k <= 36; k++) begin
            model_cycle(2'b11, mk(1'b1, 1'b0, 1'b0, 8'h01, 32'h0, 128'(k)),
                        mk(1'b1, 1'b0, 1'b0, 8'h02, 32'h0, 128'(32'h100 + k)));
        end
        check("ovf_saw_full0", RW'(saw_full0), RW'(1'b1));
        check("ovf_both_set", RW'(ovf_o), RW'(2'b11));
        for (int k = 1; k <= 40; k++) begin
            model_cycle(2'b00, '0, '0);
        end
        check("drain_resp", resp_o, '0);
        check("drain_full", RW'(full_o), RW'(2'b00));
        check("drain_ovf_sticky", RW'(ovf_o), RW'(2'b11));

        // ack=0 with rty/err set is not an entry.
        resp[0 +: RW] = mk(1'b0, 1'b1, 1'b1, 8'h05, 32'h3000, 128'hDEAD);
        step();
        step();
        resp = '0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("ignored", resp_o, '0);
        end
        check("ignored_ovf", RW'(ovf_o), RW'(2'b11));

        // Asynchronous reset mid-burst with entries buffered.
        for (int k = 1; k <= 3; k++) begin
            resp[0 +: RW]  = mk(1'b1, 1'b0, 1'b0, 8'h01, 32'h4000, 128'(k));
            resp[RW +: RW] = mk(1'b1, 1'b0, 1'b0, 8'h02, 32'h4000, 128'(k + 8));
            step();
        end
        resp = '0;
        check("pre_rst_ack", RW'(resp_o[0]), RW'(1'b1));
        #3;
        rst = 1'b0;
        #1;
        check("async_resp", resp_o, '0);
        check("async_full", RW'(full_o), RW'(2'b00));
        check("async_ovf", RW'(ovf_o), RW'(2'b00));
        step();
        #2;
        rst = 1'b1;
        // First cycle after release captures normally.
        e_a = mk(1'b1, 1'b0, 1'b0, 8'h02, 32'h5000, 128'h77);
        resp[RW +: RW] = e_a;
        step();
        resp = '0;
        check("release_t1", resp_o, '0);
        step();
        check("release_t2", resp_o, e_a);
        for (int k = 0; k < 4; k++) begin
            step();
            check("no_stale", resp_o, '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
